// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: registers state ^ round key and expands the key one round per accept.
// SubWord is borrowed from a shared external S-box through the sw_in/sw_out pair.
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load,
  input  logic [127:0]         key_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:3][0:3][7:0] in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:3][0:3][7:0] out_state,
  output logic [3:0]           out_round,
  output logic                 out_last,
  output logic [31:0]          sw_in,
  input  logic [31:0]          sw_out,
  output logic                 key_ready
);
  typedef logic [0:3][0:3][7:0] state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  logic [127:0] cur_key_q, cur_key_d;
  logic [127:0] base_key_q, base_key_d;
  logic [127:0] next_key;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         key_ready_q, key_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic [3:0]   out_round_q, out_round_d;
  state_t       out_state_q, out_state_d;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic         accept;
  logic         last_rnd;

  // Byte k of the flat vector sits at row k%4, column k/4 of the state array.
  function automatic logic [127:0] state_to_bytes(input state_t s);
    logic [127:0] b;
    logic [1:0]   r, c;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      r = 2'(k % 4);
      c = 2'(k / 4);
      b[127-8*k -: 8] = s[r][c];
    end
    return b;
  endfunction

  function automatic state_t bytes_to_state(input logic [127:0] b);
    state_t     s;
    logic [1:0] r, c;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      r = 2'(k % 4);
      c = 2'(k / 4);
      s[r][c] = b[127-8*k -: 8];
    end
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // w3 is the low word of cur_key; RotWord moves its top byte to the bottom.
  assign sw_in = {cur_key_q[23:0], cur_key_q[31:24]};
  assign w0n   = cur_key_q[127:96] ^ sw_out ^ {rcon_q, 24'h0};
  assign w1n   = cur_key_q[95:64] ^ w0n;
  assign w2n   = cur_key_q[63:32] ^ w1n;
  assign w3n   = cur_key_q[31:0]  ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  assign last_rnd = (rnd_q == NR_L);
  assign in_ready = key_ready_q & ~key_load & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    cur_key_d   = cur_key_q;
    base_key_d  = base_key_q;
    rcon_d      = rcon_q;
    rnd_d       = rnd_q;
    key_ready_d = key_ready_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    if (key_load) begin
      base_key_d  = key_in;
      cur_key_d   = key_in;
      rnd_d       = 4'd0;
      rcon_d      = 8'h01;
      key_ready_d = 1'b1;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_state_d = bytes_to_state(state_to_bytes(in_state) ^ cur_key_q);
      out_round_d = rnd_q;
      out_last_d  = last_rnd;
      // After the final round, rewind to the cipher key so the next block needs no reload.
      if (last_rnd) begin
        cur_key_d = base_key_q;
        rnd_d     = 4'd0;
        rcon_d    = 8'h01;
      end else begin
        cur_key_d = next_key;
        rnd_d     = rnd_q + 4'd1;
        rcon_d    = xtime(rcon_q);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output / key-schedule register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_key_q   <= '0;
      base_key_q  <= '0;
      rcon_q      <= 8'h01;
      rnd_q       <= 4'd0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      cur_key_q   <= cur_key_d;
      base_key_q  <= base_key_d;
      rcon_q      <= rcon_d;
      rnd_q       <= rnd_d;
      key_ready_q <= key_ready_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign key_ready = key_ready_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: FIPS-197 vectors plus randomized traffic against a
// reference model built on the textbook AES-128 key expansion.
module tb_add_round_key_stage;
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 key_load = 1'b0;
  logic [127:0]         key_in = '0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic [0:3][0:3][7:0] in_state = '0;
  logic                 in_ready, out_valid, out_last, key_ready;
  logic [0:3][0:3][7:0] out_state;
  logic [3:0]           out_round;
  logic [31:0]          sw_in;
  wire  [31:0]          sw_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk [11];

  // reference model state
  bit           chk_en = 1'b0;
  logic         m_kr = 1'b0, m_ov = 1'b0, m_ol = 1'b0;
  logic [127:0] m_os = '0;
  logic [3:0]   m_or = '0, m_rnd = '0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  assign sw_out = {sbox[sw_in[31:24]], sbox[sw_in[23:16]], sbox[sw_in[15:8]], sbox[sw_in[7:0]]};

  add_round_key_stage #(.NR(10)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_last(out_last),
    .sw_in(sw_in), .sw_out(sw_out), .key_ready(key_ready)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] to_bytes(input logic [0:3][0:3][7:0] s);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[127-8*k -: 8] = s[k%4][k/4];
    return b;
  endfunction

  function automatic logic [0:3][0:3][7:0] to_state(input logic [127:0] b);
    logic [0:3][0:3][7:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s[k%4][k/4] = b[127-8*k -: 8];
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Standard FIPS-197 key expansion into 44 words, grouped into 11 round keys.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    step();
    key_load = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: one output slot, round counter 0..10 wrapping, keys from the expanded schedule.
  always @(posedge clk) begin
    logic acc;
    if (rst) begin
      chk_en = 1'b1;
      m_kr = 1'b0; m_ov = 1'b0; m_ol = 1'b0;
      m_os = '0; m_or = '0; m_rnd = '0;
    end else if (key_load) begin
      m_kr  = 1'b1;
      expand(key_in);
      m_rnd = '0;
      m_ov  = 1'b0;
    end else begin
      acc = in_valid && m_kr && (!m_ov || out_ready);
      if (acc) begin
        m_os  = to_bytes(in_state) ^ rk[m_rnd];
        m_or  = m_rnd;
        m_ol  = (m_rnd == 4'd10);
        m_rnd = (m_rnd == 4'd10) ? 4'd0 : m_rnd + 4'd1;
        m_ov  = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chkb("out_valid", out_valid, m_ov);
      chkb("in_ready", in_ready, m_kr && !key_load && (!m_ov || out_ready));
      chkb("key_ready", key_ready, m_kr);
      chkw("out_state", to_bytes(out_state), m_os);
      chkw("out_round", 128'(out_round), 128'(m_or));
      chkb("out_last", out_last, m_ol);
    end
  end

  initial begin
    logic [127:0] held, k2;
    logic [3:0]   hr;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    // reset and pre-key behaviour
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_key_ready", key_ready, 1'b0);
    chkw("rst_out_state", to_bytes(out_state), 128'h0);
    in_valid = 1'b1;
    in_state = to_state(rand128());
    #1 chkb("prekey_in_ready", in_ready, 1'b0);
    repeat (3) step();
    chkb("prekey_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;

    // FIPS-197 App.B round 0 and round 1
    load_key(K1);
    chkw("model_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chkw("model_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    in_valid = 1'b1;
    in_state = to_state(128'h3243f6a8885a308d313198a2e0370734);
    step();
    chkw("r0_state", to_bytes(out_state), 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chkw("r0_round", 128'(out_round), 128'd0);
    chkb("r0_last", out_last, 1'b0);
    in_state = to_state(128'h046681e5e0cb199a48f8d37a2806264c);
    step();
    in_valid = 1'b0;
    chkw("r1_state", to_bytes(out_state), 128'ha49c7ff2689f352b6b5bea43026a5049);
    chkw("r1_round", 128'(out_round), 128'd1);

    // full block of zero states exposes the round keys, then wraps
    load_key(K1);
    in_valid = 1'b1;
    in_state = '0;
    for (int i = 0; i < 11; i++) begin
      step();
      chkw("blk_rk", to_bytes(out_state), rk[i]);
    end
    chkw("blk_last_key", to_bytes(out_state), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chkb("blk_last_flag", out_last, 1'b1);
    step();
    chkw("wrap_state", to_bytes(out_state), K1);
    chkw("wrap_round", 128'(out_round), 128'd0);
    chkb("wrap_last", out_last, 1'b0);

    // backpressure
    in_state = to_state(rand128());
    step();
    out_ready = 1'b0;
    held = to_bytes(out_state);
    hr = out_round;
    in_state = to_state(rand128());
    for (int i = 0; i < 5; i++) begin
      step();
      chkb("bp_in_ready", in_ready, 1'b0);
      chkw("bp_hold_state", to_bytes(out_state), held);
      chkw("bp_hold_round", 128'(out_round), 128'(hr));
    end
    out_ready = 1'b1;
    #1 chkb("bp_release_ready", in_ready, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chkb("bp_thru_valid", out_valid, 1'b1);
      chkw("bp_thru_round", 128'(out_round), 128'(hr + 4'(i)));
    end
    in_valid = 1'b0;

    // key reload mid-block
    load_key(K1);
    in_valid = 1'b1;
    repeat (4) begin
      in_state = to_state(rand128());
      step();
    end
    k2 = rand128();
    key_load = 1'b1;
    key_in = k2;
    #1 chkb("kl_in_ready", in_ready, 1'b0);
    step();
    key_load = 1'b0;
    chkb("kl_out_valid", out_valid, 1'b0);
    in_state = '0;
    step();
    in_valid = 1'b0;
    chkw("kl_new_key", to_bytes(out_state), k2);
    chkw("kl_round", 128'(out_round), 128'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_state  = to_state(rand128());
      key_load  = ($urandom_range(0, 99) == 0);
      key_in    = rand128();
      step();
    end
    key_load = 1'b0;

    // reset mid-block
    in_valid = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chkb("mrst_out_valid", out_valid, 1'b0);
    chkb("mrst_key_ready", key_ready, 1'b0);
    #1 chkb("mrst_in_ready", in_ready, 1'b0);
    repeat (3) step();
    chkb("mrst_ignored", out_valid, 1'b0);
    load_key(K1);
    in_state = to_state(128'h3243f6a8885a308d313198a2e0370734);
    step();
    in_valid = 1'b0;
    chkw("mrst_r0_state", to_bytes(out_state), 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
